// File: rtl/hpgp_mlen_pkg.sv
// Shared constants, FSM state type and header field helpers for the M_LEN
// receive parser.
package hpgp_mlen_pkg;

  localparam int DW    = 13;
  localparam int LID_W = 6;
  localparam logic [5:0] SYNC_PAT = 6'b101101;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LEN  = 2'd1,
    PAY  = 2'd2,
    CHK  = 2'd3
  } state_t;

  // Header word layout: {SYNC_PAT, 1'b0, link_id}
  function automatic logic is_header(input logic [DW-1:0] word);
    return (word[12:7] == SYNC_PAT) && (word[6] == 1'b0);
  endfunction

  function automatic logic [LID_W-1:0] hdr_lid(input logic [DW-1:0] word);
    return word[LID_W-1:0];
  endfunction

endpackage

// File: rtl/hpgp_gap_timer.sv
// Counts consecutive idle cycles while enabled; pulses expired on the cycle
// the idle run reaches GAP_TO.
module hpgp_gap_timer #(
  parameter int GAP_TO = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic kick,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(GAP_TO + 1);

  logic [CW-1:0] count;

  assign expired = enable && !kick && !clear && (count == CW'(GAP_TO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || kick || expired) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hpgp_mlen_rx.sv
// Receive-side parser for the 13-bit M_LEN word stream: header hunt, length
// check, payload forwarding and trailing checksum verification.
module hpgp_mlen_rx
  import hpgp_mlen_pkg::*;
#(
  parameter int MAX_LEN = 4096,
  parameter int GAP_TO  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic             out_last,
  output logic [LID_W-1:0] link_id,
  output logic [DW-1:0]    m_len,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_err
);

  state_t        state;
  logic [DW-1:0] cnt;
  logic [DW-1:0] sum;
  logic          gap_expired;

  hpgp_gap_timer #(
    .GAP_TO(GAP_TO)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (state != HUNT),
    .kick   (in_valid),
    .clear  (state == HUNT),
    .expired(gap_expired)
  );

  // A gap timeout overrides everything else; otherwise the FSM only moves on valid words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      cnt        <= '0;
      sum        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      link_id    <= '0;
      m_len      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (gap_expired) begin
        frame_err <= 1'b1;
        busy      <= 1'b0;
        state     <= HUNT;
      end else if (in_valid) begin
        case (state)
          HUNT: begin
            if (is_header(in_data)) begin
              link_id <= hdr_lid(in_data);
              busy    <= 1'b1;
              state   <= LEN;
            end
          end
          LEN: begin
            if ((in_data != '0) && (in_data <= DW'(MAX_LEN))) begin
              m_len <= in_data;
              sum   <= '0;
              cnt   <= '0;
              state <= PAY;
            end else begin
              frame_err <= 1'b1;
              busy      <= 1'b0;
              state     <= HUNT;
            end
          end
          PAY: begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            sum       <= sum + in_data;
            cnt       <= cnt + 1'b1;
            if (cnt == m_len - 1'b1) begin
              out_last <= 1'b1;
              state    <= CHK;
            end
          end
          CHK: begin
            if (in_data == sum) begin
              frame_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            busy  <= 1'b0;
            state <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hpgp_mlen_rx.sv
// Scoreboard bench for hpgp_mlen_rx: expected payload words and frame events
// are queued as stimulus is driven and matched as the parser produces them.
module tb_hpgp_mlen_rx;

  localparam int MAX_LEN = 4096;
  localparam int GAP_TO  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [12:0] in_data = '0;
  logic        out_valid;
  logic [12:0] out_data;
  logic        out_last;
  logic [5:0]  link_id;
  logic [12:0] m_len;
  logic        busy;
  logic        frame_done;
  logic        frame_err;

  typedef struct packed {
    logic [12:0] data;
    logic        last;
  } out_exp_t;

  typedef struct packed {
    logic        is_err;
    logic [5:0]  lid;
    logic [12:0] len;
    logic        chk_len;
  } ev_exp_t;

  out_exp_t    out_q[$];
  ev_exp_t     ev_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [12:0] pay_buf [0:MAX_LEN-1];

  hpgp_mlen_rx dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .link_id   (link_id),
    .m_len     (m_len),
    .busy      (busy),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [12:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
  endtask

  // Drives a complete frame from pay_buf; leaves in_valid high for back-to-back use.
  task automatic sendFrame(input logic [5:0] lid, input int len, input logic bad_check);
    logic [12:0] chk;
    out_exp_t    oe;
    ev_exp_t     ee;
    chk = '0;
    applyStimulus(1'b1, {6'b101101, 1'b0, lid});
    applyStimulus(1'b1, 13'(len));
    for (int i = 0; i < len; i++) begin
      oe.data = pay_buf[i];
      oe.last = (i == len - 1);
      out_q.push_back(oe);
      chk = chk + pay_buf[i];
      applyStimulus(1'b1, pay_buf[i]);
    end
    ee.is_err  = bad_check;
    ee.lid     = lid;
    ee.len     = 13'(len);
    ee.chk_len = 1'b1;
    ev_q.push_back(ee);
    applyStimulus(1'b1, bad_check ? chk + 13'd1 : chk);
  endtask

  task automatic badLengthFrame(input logic [5:0] lid, input logic [12:0] len);
    ev_exp_t ee;
    ee.is_err  = 1'b1;
    ee.lid     = lid;
    ee.len     = len;
    ee.chk_len = 1'b0;
    applyStimulus(1'b1, {6'b101101, 1'b0, lid});
    ev_q.push_back(ee);
    applyStimulus(1'b1, len);
    applyStimulus(1'b0, '0);
    checkOutput("busy_after_bad_len", busy, 0);
  endtask

  // Output monitor: every forwarded word and every frame event must match the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (out_q.size() == 0) begin
          checkOutput("unexpected_out_valid", 1, 0);
        end else begin
          out_exp_t oe;
          oe = out_q.pop_front();
          checkOutput("out_data", out_data, oe.data);
          checkOutput("out_last", out_last, oe.last);
        end
      end
      if (frame_done || frame_err) begin
        checkOutput("done_err_exclusive", frame_done & frame_err, 0);
        if (ev_q.size() == 0) begin
          checkOutput("unexpected_event", 1, 0);
        end else begin
          ev_exp_t ee;
          ee = ev_q.pop_front();
          checkOutput("event_is_err", frame_err, ee.is_err);
          checkOutput("event_link_id", link_id, ee.lid);
          if (ee.chk_len) checkOutput("event_m_len", m_len, ee.len);
        end
      end
    end
  end

  initial begin
    out_exp_t oe;
    ev_exp_t  ee;

    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_link_id", link_id, 0);
    checkOutput("rst_m_len", m_len, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    applyStimulus(1'b0, '0);

    $display("[TB] good frame link 4, M_LEN 3");
    pay_buf[0] = 13'd1; pay_buf[1] = 13'd2; pay_buf[2] = 13'd3;
    sendFrame(6'd4, 3, 1'b0);
    applyStimulus(1'b0, '0);
    checkOutput("t1_busy", busy, 0);
    checkOutput("t1_link_id", link_id, 4);
    checkOutput("t1_m_len", m_len, 3);

    $display("[TB] checksum mismatch");
    sendFrame(6'd4, 3, 1'b1);
    applyStimulus(1'b0, '0);
    checkOutput("t2_busy", busy, 0);

    $display("[TB] illegal lengths");
    badLengthFrame(6'd7, 13'd0);
    badLengthFrame(6'd8, 13'(MAX_LEN + 1));
    checkOutput("t3_m_len_held", m_len, 3);

    $display("[TB] gap timeout");
    applyStimulus(1'b1, {6'b101101, 1'b0, 6'd5});
    applyStimulus(1'b1, 13'd2);
    oe.data = 13'h0AA;
    oe.last = 1'b0;
    out_q.push_back(oe);
    applyStimulus(1'b1, 13'h0AA);
    checkOutput("t4_busy_in_frame", busy, 1);
    ee.is_err = 1'b1; ee.lid = 6'd5; ee.len = 13'd2; ee.chk_len = 1'b1;
    ev_q.push_back(ee);
    repeat (GAP_TO) applyStimulus(1'b0, '0);
    checkOutput("t4_no_early_err", frame_err, 0);
    checkOutput("t4_busy_before_to", busy, 1);
    applyStimulus(1'b0, '0);
    checkOutput("t4_err_at_timeout", frame_err, 1);
    checkOutput("t4_busy_after_to", busy, 0);
    pay_buf[0] = 13'd10; pay_buf[1] = 13'd20;
    sendFrame(6'd5, 2, 1'b0);
    applyStimulus(1'b0, '0);

    $display("[TB] garbage in hunt, header-like payload");
    applyStimulus(1'b1, 13'h1FFF);
    applyStimulus(1'b1, 13'h0B40);
    pay_buf[0] = 13'h16C5; pay_buf[1] = 13'h0001;
    sendFrame(6'd9, 2, 1'b0);
    applyStimulus(1'b0, '0);

    $display("[TB] length boundaries");
    pay_buf[0] = 13'h1ABC;
    sendFrame(6'd63, 1, 1'b0);
    for (int i = 0; i < MAX_LEN; i++) pay_buf[i] = 13'($urandom);
    sendFrame(6'd2, MAX_LEN, 1'b0);
    applyStimulus(1'b0, '0);
    checkOutput("max_len_m_len", m_len, MAX_LEN);

    $display("[TB] back-to-back frames then reset mid-payload");
    pay_buf[0] = 13'd100; pay_buf[1] = 13'd200; pay_buf[2] = 13'd300;
    sendFrame(6'd4, 3, 1'b0);
    sendFrame(6'd5, 3, 1'b0);
    applyStimulus(1'b1, {6'b101101, 1'b0, 6'd6});
    applyStimulus(1'b1, 13'd4);
    for (int i = 0; i < 2; i++) begin
      oe.data = 13'(7 + i);
      oe.last = 1'b0;
      out_q.push_back(oe);
      applyStimulus(1'b1, 13'(7 + i));
    end
    applyStimulus(1'b0, '0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t6_rst_out_valid", out_valid, 0);
    checkOutput("t6_rst_out_data", out_data, 0);
    checkOutput("t6_rst_out_last", out_last, 0);
    checkOutput("t6_rst_link_id", link_id, 0);
    checkOutput("t6_rst_m_len", m_len, 0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_frame_err", frame_err, 0);
    checkOutput("t6_rst_frame_done", frame_done, 0);
    rst = 1'b0;
    repeat (4) applyStimulus(1'b0, '0);
    pay_buf[0] = 13'd11; pay_buf[1] = 13'd22;
    sendFrame(6'd1, 2, 1'b0);
    repeat (4) applyStimulus(1'b0, '0);

    checkOutput("out_queue_drained", out_q.size(), 0);
    checkOutput("event_queue_drained", ev_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
